// File: rtl/input_conditioner.sv
// input_conditioner: synchronises, debounces and edge-detects four direction
// switches, then derives press pulses, hold-to-repeat pulses and a resolved
// signed move vector. Every output comes straight from a flop.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 40_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       switch_up,
    input  logic       switch_down,
    input  logic       switch_left,
    input  logic       switch_right,
    output logic [3:0] btn_level,
    output logic [3:0] btn_press,
    output logic [3:0] btn_repeat,
    output logic [1:0] move_dx,
    output logic [1:0] move_dy,
    output logic       move_valid
);
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = (REP_MAX < 1) ? 1 : $clog2(REP_MAX + 1);

    // Counter value on which the next differing cycle flips the stable state.
    localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_DELAY_V  = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_PERIOD_V = REP_W'(REPEAT_PERIOD);
    localparam logic [REP_W-1:0] REP_ONE      = REP_W'(1);

    // Bit order shared by all 4-bit buses: [0]=up [1]=down [2]=left [3]=right.
    logic [3:0] raw;
    assign raw = {switch_right, switch_left, switch_down, switch_up};

    logic [3:0]       s1_q, s1_d;
    logic [3:0]       s2_q, s2_d;
    logic [3:0]       stable_q, stable_d;
    logic [3:0]       press_q, press_d;
    logic [3:0]       repeat_q, repeat_d;
    logic [DB_W-1:0]  db_cnt_q [4];
    logic [DB_W-1:0]  db_cnt_d [4];
    logic [REP_W-1:0] rep_cnt_q [4];
    logic [REP_W-1:0] rep_cnt_d [4];
    logic [1:0]       dx_q, dx_d;
    logic [1:0]       dy_q, dy_d;
    logic             valid_q, valid_d;
    logic [3:0]       ev;

    // Two-stage synchroniser, nothing between the stages.
    always_comb begin
        s1_d = raw;
        s2_d = s1_q;
    end

    // Debounce: count consecutive cycles s2 disagrees with stable; any agreeing
    // cycle restarts the count, and the D-th disagreeing cycle flips stable.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Press on debounced rising edge; repeat counter loads on press, counts
    // down while held and fires on its last count. Looking at the next level
    // keeps a repeat from landing in the cycle the level drops.
    always_comb begin
        press_d  = stable_d & ~stable_q;
        repeat_d = '0;
        for (int i = 0; i < 4; i++) begin
            rep_cnt_d[i] = rep_cnt_q[i];
            if (press_d[i]) begin
                rep_cnt_d[i] = REP_DELAY_V;
            end else if (!stable_d[i]) begin
                rep_cnt_d[i] = '0;
            end else if (rep_cnt_q[i] == REP_ONE) begin
                repeat_d[i]  = 1'b1;
                rep_cnt_d[i] = REP_PERIOD_V;
            end else if (rep_cnt_q[i] != '0) begin
                rep_cnt_d[i] = rep_cnt_q[i] - 1'b1;
            end
        end
    end

    // Move resolution: an event steps only if the opposing button is not held.
    always_comb begin
        ev   = press_q | repeat_q;
        dx_d = 2'b00;
        dy_d = 2'b00;
        if (ev[3] && !stable_q[2]) begin
            dx_d = 2'b01;
        end else if (ev[2] && !stable_q[3]) begin
            dx_d = 2'b11;
        end
        if (ev[1] && !stable_q[0]) begin
            dy_d = 2'b01;
        end else if (ev[0] && !stable_q[1]) begin
            dy_d = 2'b11;
        end
        valid_d = (dx_d != 2'b00) || (dy_d != 2'b00);
    end

    // State register; every flop clears asynchronously on reset low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            press_q  <= '0;
            repeat_q <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            valid_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i]  <= '0;
                rep_cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            repeat_q <= repeat_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            valid_q  <= valid_d;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i]  <= db_cnt_d[i];
                rep_cnt_q[i] <= rep_cnt_d[i];
            end
        end
    end

    assign btn_level  = stable_q;
    assign btn_press  = press_q;
    assign btn_repeat = repeat_q;
    assign move_dx    = dx_q;
    assign move_dy    = dy_q;
    assign move_valid = valid_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=5. A window-based reference model is compared every cycle;
// a vector table and hand sequences pin down the documented scenarios.
module tb_input_conditioner;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic       clk;
    logic       reset;
    logic [3:0] sw;
    logic [3:0] btn_level, btn_press, btn_repeat;
    logic [1:0] move_dx, move_dy;
    logic       move_valid;

    int n_checks = 0;
    int n_fail   = 0;

    input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .switch_up   (sw[0]),
        .switch_down (sw[1]),
        .switch_left (sw[2]),
        .switch_right(sw[3]),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_repeat  (btn_repeat),
        .move_dx     (move_dx),
        .move_dy     (move_dy),
        .move_valid  (move_valid)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. Stable flips when the last DB synchronised samples
    // (raw samples from 2..DB+1 edges ago) all disagree with it. Repeats are
    // derived from the age of the current hold.
    logic [3:0] m_hist[$];
    logic [3:0] m_lvl, m_press, m_rep;
    logic [1:0] m_dx, m_dy;
    logic       m_valid;
    int         m_age[4];

    task automatic model_reset();
        m_hist.delete();
        for (int k = 0; k <= DB; k++) m_hist.push_back(4'b0000);
        m_lvl = '0; m_press = '0; m_rep = '0;
        m_dx = '0; m_dy = '0; m_valid = 1'b0;
        for (int i = 0; i < 4; i++) m_age[i] = -1;
    endtask

    task automatic model_step(input logic [3:0] raw);
        logic [3:0] ev;
        logic [3:0] nl;
        logic [3:0] w;
        int dx, dy;
        bit all_diff;
        ev = m_press | m_rep;
        dx = 0;
        dy = 0;
        if (ev[3] && !m_lvl[2]) dx = 1;
        else if (ev[2] && !m_lvl[3]) dx = -1;
        if (ev[1] && !m_lvl[0]) dy = 1;
        else if (ev[0] && !m_lvl[1]) dy = -1;
        nl = m_lvl;
        for (int i = 0; i < 4; i++) begin
            all_diff = 1'b1;
            for (int k = 0; k < DB; k++) begin
                w = m_hist[k];
                if (w[i] == m_lvl[i]) all_diff = 1'b0;
            end
            if (all_diff) nl[i] = ~m_lvl[i];
        end
        m_hist.push_back(raw);
        void'(m_hist.pop_front());
        m_press = nl & ~m_lvl;
        for (int i = 0; i < 4; i++) begin
            m_rep[i] = 1'b0;
            if (!nl[i]) m_age[i] = -1;
            else if (m_press[i]) m_age[i] = 0;
            else begin
                m_age[i]++;
                if (RD != 0 && m_age[i] >= RD && ((m_age[i] - RD) % RP) == 0) m_rep[i] = 1'b1;
            end
        end
        m_lvl   = nl;
        m_dx    = dx[1:0];
        m_dy    = dy[1:0];
        m_valid = (dx != 0) || (dy != 0);
    endtask

    // One clock: advance the model with the values present at the edge,
    // then compare the DUT just after the edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset();
        else model_step(sw);
        #1;
        check("level", int'(btn_level), int'(m_lvl));
        check("press", int'(btn_press), int'(m_press));
        check("repeat", int'(btn_repeat), int'(m_rep));
        check("move", int'({move_valid, move_dx, move_dy}), int'({m_valid, m_dx, m_dy}));
    endtask

    // Scoreboard of expected repeat offsets (cycles after the press).
    int exp_q[$];

    // Hold 'mask' for 'hold' cycles within 'total' cycles; expects one press
    // at cycle 6 and repeats at the offsets queued in exp_q.
    task automatic run_hold(input string name, input logic [3:0] mask, input int hold,
                            input int total, input int exp_move);
        int press_tick = -1;
        int n_press = 0;
        bit prev_ev = 1'b0;
        for (int k = 1; k <= total; k++) begin
            sw = (k <= hold) ? mask : 4'b0000;
            tick();
            if (prev_ev) check({name, "_move"}, int'({move_valid, move_dx, move_dy}), exp_move);
            prev_ev = 1'b0;
            if ((btn_press & mask) != 0) begin
                n_press++;
                press_tick = k;
                prev_ev = 1'b1;
            end
            if ((btn_repeat & mask) != 0) begin
                prev_ev = 1'b1;
                if (exp_q.size() == 0) check({name, "_rep_unexpected"}, k - press_tick, -1);
                else check({name, "_rep_offset"}, k - press_tick, exp_q.pop_front());
            end
        end
        check({name, "_press_count"}, n_press, 1);
        check({name, "_press_tick"}, press_tick, 6);
        check({name, "_rep_missing"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    typedef struct {
        logic [3:0] sw;
        int         ticks;
        logic [3:0] exp_lvl;
        int         exp_press;
        int         exp_rep;
        int         exp_valid;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int np, nr, nv, rst_hold;

        vecs[0] = '{4'b0000,  8, 4'b0000, 0, 0, 0};
        vecs[1] = '{4'b1000,  3, 4'b0000, 0, 0, 0};  // glitch shorter than debounce
        vecs[2] = '{4'b0000,  8, 4'b0000, 0, 0, 0};
        vecs[3] = '{4'b1000, 18, 4'b1000, 1, 1, 2};  // right press + first repeat
        vecs[4] = '{4'b1100, 12, 4'b1100, 1, 2, 1};  // left joins: opposing cancel
        vecs[5] = '{4'b1000, 12, 4'b1000, 0, 4, 2};  // left released, right steps again
        vecs[6] = '{4'b0000, 12, 4'b0000, 0, 1, 1};
        vecs[7] = '{4'b0101, 10, 4'b0101, 2, 0, 1};  // up+left together
        vecs[8] = '{4'b0000, 10, 4'b0000, 0, 0, 0};

        // Reset with all switches high, then release.
        sw = 4'b1111;
        reset = 1'b1;
        model_reset();
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("rst_outputs", int'({btn_level, btn_press, btn_repeat, move_valid, move_dx, move_dy}), 0);
        reset = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 5) check("rst_rel_level_k5", int'(btn_level), 0);
            if (k == 6) begin
                check("rst_rel_level_k6", int'(btn_level), 15);
                check("rst_rel_press_k6", int'(btn_press), 15);
            end
            if (k == 7) begin
                check("rst_rel_press_k7", int'(btn_press), 0);
                check("rst_rel_valid_k7", int'(move_valid), 0);
            end
        end
        sw = 4'b0000;
        for (int k = 0; k < 12; k++) tick();

        // Table-driven vectors.
        for (int v = 0; v < 9; v++) begin
            np = 0; nr = 0; nv = 0;
            sw = vecs[v].sw;
            for (int k = 0; k < vecs[v].ticks; k++) begin
                tick();
                np += $countones(btn_press);
                nr += $countones(btn_repeat);
                nv += int'(move_valid);
            end
            check($sformatf("vec%0d_level", v), int'(btn_level), int'(vecs[v].exp_lvl));
            check($sformatf("vec%0d_press", v), np, vecs[v].exp_press);
            check($sformatf("vec%0d_repeat", v), nr, vecs[v].exp_rep);
            check($sformatf("vec%0d_valid", v), nv, vecs[v].exp_valid);
        end

        // Hold up for 40 cycles: repeats at +10..+35, each moving dy=-1.
        exp_q = '{10, 15, 20, 25, 30, 35};
        run_hold("hold_up", 4'b0001, 40, 55, 5'b1_00_11);
        // Release mid-repeat, then a fresh press restarts the delay.
        exp_q = '{10};
        run_hold("rel_mid", 4'b0001, 12, 25, 5'b1_00_11);
        exp_q = '{10};
        run_hold("repress", 4'b0001, 13, 25, 5'b1_00_11);

        // Async reset during a repeat sequence on right.
        sw = 4'b1000;
        for (int k = 0; k < 20; k++) tick();
        #2 reset = 1'b0;
        #1;
        check("arst_level", int'(btn_level), 0);
        check("arst_press", int'(btn_press), 0);
        check("arst_repeat", int'(btn_repeat), 0);
        check("arst_move", int'({move_valid, move_dx, move_dy}), 0);
        for (int k = 0; k < 3; k++) tick();
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 6) check("arst_fresh_press", int'(btn_press), 8);
        end
        sw = 4'b0000;
        for (int k = 0; k < 12; k++) tick();

        // Randomised toggling with occasional resets, checked by the model.
        rst_hold = 0;
        for (int k = 0; k < 2500; k++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 15) == 0) sw[i] = ~sw[i];
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) reset = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                rst_hold = $urandom_range(1, 3);
            end
            tick();
        end
        reset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
